// File: rtl/one_shot_debouncer_array.sv
// rtl/one_shot_debouncer_array.sv - bank of independent one-shot input debouncers
//
// Purpose:
//   Each channel synchronises a raw asynchronous input with two flip-flops.
//   It then qualifies the input as high for STABLE_CYCLES clocks before it
//   emits a single-cycle press pulse and raises the debounced level. A release
//   hold-off of HOLDOFF_CYCLES low clocks is required before the channel
//   re-arms.
//
// Optional feature macro: RELEASE_PULSE_EN
//   When defined, release_pulse[i] pulses for one cycle on the same edge that
//   level[i] falls. When undefined, release_pulse is tied to 0.
//
// Ports:
//   clk            in   1         single clock, rising edge
//   rst_n          in   1         asynchronous active-low reset
//   din            in   CHANNELS  raw inputs, asynchronous to clk, active high
//   level          out  CHANNELS  debounced level per channel (registered)
//   press          out  CHANNELS  one-cycle pulse per qualified press
//   release_pulse  out  CHANNELS  one-cycle pulse per qualified release
//   press_any      out  1         OR of press

module one_shot_debouncer_array #(
    parameter int CHANNELS       = 4,
    parameter int STABLE_CYCLES  = 128,
    parameter int HOLDOFF_CYCLES = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                press_any
);

    localparam int MAX_CYCLES = (STABLE_CYCLES > HOLDOFF_CYCLES) ? STABLE_CYCLES : HOLDOFF_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] STABLE_CNT  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] HOLDOFF_CNT = CW'(HOLDOFF_CYCLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HELD = 2'd2,
        HOLD = 2'd3
    } state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          sync1;
        logic          s;
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          level_q;
        logic          level_nxt;
        logic          press_q;
        logic          press_nxt;

        // Two-stage synchroniser; only s is used downstream.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= 1'b0;
                s     <= 1'b0;
            end else begin
                sync1 <= din[i];
                s     <= sync1;
            end
        end

        // State register, plus registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= IDLE;
                cnt     <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                level_q <= level_nxt;
                press_q <= press_nxt;
            end
        end

        // Next-state and counter. The counter is reset on every transition,
        // so it never exceeds the threshold of the state it is counting in.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                IDLE: begin
                    if (s) begin
                        state_nxt = ARM;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                ARM: begin
                    if (!s) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == STABLE_CNT) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_nxt = HOLD;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                HOLD: begin
                    if (s) begin
                        // Bounce during release: go back to held without a new press.
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt == HOLDOFF_CNT) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Output logic: press is a single-cycle pulse; level holds otherwise.
        always_comb begin
            press_nxt = 1'b0;
            level_nxt = level_q;
            if (state == ARM && s && cnt == STABLE_CNT) begin
                press_nxt = 1'b1;
                level_nxt = 1'b1;
            end
            if (state == HOLD && !s && cnt == HOLDOFF_CNT) begin
                level_nxt = 1'b0;
            end
        end

`ifdef RELEASE_PULSE_EN
        logic release_q;
        logic release_nxt;

        always_comb begin
            release_nxt = 1'b0;
            if (state == HOLD && !s && cnt == HOLDOFF_CNT) begin
                release_nxt = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                release_q <= 1'b0;
            end else begin
                release_q <= release_nxt;
            end
        end

        assign release_pulse[i] = release_q;
`else
        assign release_pulse[i] = 1'b0;
`endif

        assign level[i] = level_q;
        assign press[i] = press_q;
    end

    assign press_any = |press;

endmodule

// File: tb/tb_one_shot_debouncer_array.sv
// tb/tb_one_shot_debouncer_array.sv - self-checking bench for one_shot_debouncer_array

module tb_one_shot_debouncer_array;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] din;
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] release_pulse;
    logic          press_any;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;

    typedef struct {
        int            at;
        logic [CH-1:0] val;
    } event_t;

    event_t press_q[$];
    event_t rel_q[$];

    one_shot_debouncer_array #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (8),
        .HOLDOFF_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .press_any    (press_any)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    task automatic push_press(input int at, input logic [CH-1:0] val);
        event_t ev;
        ev.at  = at;
        ev.val = val;
        press_q.push_back(ev);
    endtask

    task automatic push_rel(input int at, input logic [CH-1:0] val);
`ifdef RELEASE_PULSE_EN
        event_t ev;
        ev.at  = at;
        ev.val = val;
        rel_q.push_back(ev);
`else
        if (at < 0 && val != 0) $display("note: unused release event");
`endif
    endtask

    // Scoreboard monitor: pops expected pulses as the DUT produces them.
    always @(negedge clk) begin
        event_t ev;
        chk("press_any", {31'd0, press_any}, {31'd0, |press});
        if (press_q.size() != 0 && press_q[0].at < edge_cnt) begin
            chk("press_missed_at", edge_cnt, press_q[0].at);
            void'(press_q.pop_front());
        end
        if (press !== '0) begin
            if (press_q.size() == 0) begin
                chk("press_unexpected", {28'd0, press}, 32'd0);
            end else begin
                ev = press_q.pop_front();
                chk("press_val", {28'd0, press}, {28'd0, ev.val});
                chk("press_edge", edge_cnt, ev.at);
            end
        end
        if (rel_q.size() != 0 && rel_q[0].at < edge_cnt) begin
            chk("release_missed_at", edge_cnt, rel_q[0].at);
            void'(rel_q.pop_front());
        end
        if (release_pulse !== '0) begin
            if (rel_q.size() == 0) begin
                chk("release_unexpected", {28'd0, release_pulse}, 32'd0);
            end else begin
                ev = rel_q.pop_front();
                chk("release_val", {28'd0, release_pulse}, {28'd0, ev.val});
                chk("release_edge", edge_cnt, ev.at);
            end
        end
    end

    initial begin
        int n;
        int m;
        int p;
        int q;

        // 1: reset with inputs high, then idle inputs.
        rst_n = 1'b0;
        din   = 4'hF;
        #1;
        chk("rst_level_now", {28'd0, level}, 32'd0);
        chk("rst_press_now", {28'd0, press}, 32'd0);
        chk("rst_release_now", {28'd0, release_pulse}, 32'd0);
        @(negedge clk);
        go_to(edge_cnt + 4);
        chk("rst_level_held", {28'd0, level}, 32'd0);
        din   = 4'h0;
        rst_n = 1'b1;
        go_to(edge_cnt + 20);
        chk("idle_level", {28'd0, level}, 32'd0);

        // 2: clean press on channel 0.
        n   = edge_cnt;
        din = 4'b0001;
        push_press(n + 11, 4'b0001);
        go_to(n + 10);
        chk("clean_level_before", {28'd0, level}, 32'd0);
        go_to(n + 11);
        chk("clean_level_after", {28'd0, level}, 32'h1);
        go_to(n + 16);
        chk("clean_level_hold", {28'd0, level}, 32'h1);

        // 4: release with a glitch inside the hold-off window.
        m      = edge_cnt;
        din[0] = 1'b0;
        go_to(m + 2);
        din[0] = 1'b1;
        go_to(m + 4);
        din[0] = 1'b0;
        push_rel(m + 11, 4'b0001);
        go_to(m + 6);
        chk("glitch_level", {28'd0, level}, 32'h1);
        go_to(m + 10);
        chk("holdoff_level_before", {28'd0, level}, 32'h1);
        go_to(m + 11);
        chk("holdoff_level_after", {28'd0, level}, 32'h0);
        go_to(m + 14);

        // 3: bouncing input on channel 1, then a clean press.
        for (int r = 0; r < 6; r++) begin
            n      = edge_cnt;
            din[1] = 1'b1;
            go_to(n + 5);
            din[1] = 1'b0;
            go_to(n + 6);
        end
        chk("bounce_level", {28'd0, level}, 32'h0);
        n      = edge_cnt;
        din[1] = 1'b1;
        push_press(n + 11, 4'b0010);
        go_to(n + 10);
        chk("bounce_level_before", {28'd0, level}, 32'h0);
        go_to(n + 11);
        chk("bounce_level_after", {28'd0, level}, 32'h2);
        go_to(n + 12);
        p      = edge_cnt;
        din[1] = 1'b0;
        push_rel(p + 7, 4'b0010);
        go_to(p + 6);
        chk("ch1_level_before_rel", {28'd0, level}, 32'h2);
        go_to(p + 7);
        chk("ch1_level_after_rel", {28'd0, level}, 32'h0);
        go_to(p + 10);

        // 5: simultaneous press on channels 1 and 3.
        n   = edge_cnt;
        din = 4'b1010;
        push_press(n + 11, 4'b1010);
        go_to(n + 11);
        chk("simul_press_any_on", {31'd0, press_any}, 32'h1);
        chk("simul_level", {28'd0, level}, 32'ha);
        go_to(n + 12);
        chk("simul_press_any_off", {31'd0, press_any}, 32'h0);
        p   = edge_cnt;
        din = 4'b0000;
        push_rel(p + 7, 4'b1010);
        go_to(p + 10);
        chk("simul_level_released", {28'd0, level}, 32'h0);

        // 6: reset while channel 2 is arming and channel 3 is held.
        n   = edge_cnt;
        din = 4'b1000;
        push_press(n + 11, 4'b1000);
        go_to(n + 12);
        n   = edge_cnt;
        din = 4'b1100;
        go_to(n + 7);
        rst_n = 1'b0;
        #1;
        chk("midrst_level_now", {28'd0, level}, 32'h0);
        chk("midrst_press_now", {28'd0, press}, 32'h0);
        go_to(edge_cnt + 3);
        chk("midrst_level_held", {28'd0, level}, 32'h0);
        q     = edge_cnt;
        rst_n = 1'b1;
        push_press(q + 11, 4'b1100);
        go_to(q + 10);
        chk("rearm_level_before", {28'd0, level}, 32'h0);
        go_to(q + 11);
        chk("rearm_level_after", {28'd0, level}, 32'hc);
        go_to(q + 13);
        p   = edge_cnt;
        din = 4'b0000;
        push_rel(p + 7, 4'b1100);
        go_to(p + 12);
        chk("final_level", {28'd0, level}, 32'h0);
        chk("press_queue_empty", press_q.size(), 32'd0);
        chk("release_queue_empty", rel_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
